pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the segmented ARMv8 datapath (IF/ID, ID/EX, EX/MEM, MEM/WB boundaries).
- Generalises the fixed-width reset register to WIDTH bits and DEPTH chained stages.
- Adds per-stage valid tracking, stall (hold), flush (bubble insertion) and a configurable reset value.
- The hazard unit drives stall/flush; downstream stages consume q/q_valid.

Parameters:
- WIDTH, 64, data bits per stage (1..128)
- DEPTH, 1, number of chained register stages = latency in advancing cycles (1..4)
- RESET_VAL, 0, value (WIDTH bits) loaded into every stage data on reset and on flush

Ports:
- clk  input  1  rising-edge clock
- Reset  input  1  synchronous reset, active-low (0 = reset, sampled on posedge clk)
- d  input  WIDTH  data into stage 0
- d_valid  input  1  d carries a real instruction/operand
- stall  input  1  1 = hold all stages this cycle
- flush  input  1  1 = clear all stages to bubbles this cycle
- q  output  WIDTH  data of last stage
- q_valid  output  1  valid bit of last stage
- occupancy  output  3  count of stages currently holding valid=1 (0..DEPTH)
- stall_cnt  output  16  stall cycle counter (see Optional Feature)

Behaviour:
- All state updates on posedge clk only; no combinational path from inputs to q/q_valid/occupancy.
- Per-edge priority: Reset==0 > flush > stall > advance.
- Reset==0: every stage data = RESET_VAL, every valid = 0; q = RESET_VAL, q_valid = 0, occupancy = 0, stall_cnt = 0. Applies mid-stall or mid-flush; the first edge with Reset==1 behaves as a normal cycle.
- flush==1 (Reset==1): all data = RESET_VAL, all valid = 0, regardless of stall and d_valid. The incoming d is discarded.
- stall==1, flush==0: every stage keeps data and valid; d/d_valid ignored.
- Advance (stall==0, flush==0):
  - stage[0] <= {d, d_valid}
  - stage[i] <= stage[i-1] for i = 1..DEPTH-1
  - q/q_valid = stage[DEPTH-1]
- Latency: d appears on q exactly DEPTH advancing edges after capture. Stalled edges add 1 each.
- Data is captured irrespective of d_valid. Invalid entries still shift, so the bubble content is deterministic (the d value present).
- occupancy: registered popcount of the valid bits, updated on the same edge as the stages (never a cycle late). With DEPTH=1 it is 0 or 1. Width stays 3 for all DEPTH.
- DEPTH=1 degenerates to a single register with enable, clear and valid.

Optional Feature:
- Macro: PIPE_STAGE_REG_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on each edge where Reset==1, flush==0 and stall==1.
  - Saturates at 16'hFFFF (no wrap).
  - Cleared only by Reset==0; flush does not clear it.
- Undefined:
  - stall_cnt tied to 16'h0000.
  - No counter flops synthesised.
  - All other behaviour identical.

Test Plan:
- Reset: hold Reset=0 for 2 edges with d=64'hDEAD_BEEF, d_valid=1 -> q=0, q_valid=0, occupancy=0. Release; next edge (DEPTH=1) -> q=64'hDEAD_BEEF, q_valid=1, occupancy=1.
- Latency, DEPTH=3, WIDTH=64, RESET_VAL=0: drive d=1,2,3,4 on consecutive edges, all valid -> q=1 on the 3rd edge after capture, then 2,3,4 on successive edges; occupancy ramps 1,2,3 and holds at 3.
- Stall, DEPTH=2: pipeline holds {A=0x10, B=0x20}; stall=1 for 3 edges with d=0x99 -> q stays 0x20, occupancy stays 2. Release -> q=0x10, then 0x99. With PIPE_STAGE_REG_STALL_CNT_EN defined, stall_cnt=3.
- Flush beats stall, DEPTH=2, RESET_VAL=64'hFFFF_FFFF_FFFF_FFFF: full pipeline; assert stall=1 and flush=1 on the same edge -> q=all ones, q_valid=0, occupancy=0; stall_cnt not incremented.
- Reset mid-operation: DEPTH=4 with 3 valid entries, stall=1, Reset=0 for one edge -> all cleared, occupancy=0, stall_cnt=0. Next edge with Reset=1, stall=0, d=0x5, d_valid=1 -> occupancy=1.
- Saturation (macro defined): force stall=1 for 65540 edges -> stall_cnt=16'hFFFF and remains there.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: DEPTH chained stages with valid, stall, flush and occupancy.
// Optional stall cycle counter enabled by defining PIPE_STAGE_REG_STALL_CNT_EN.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 64,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_d_valid,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_valid,
  output logic [2:0]       o_occupancy,
  output logic [15:0]      o_stall_cnt
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [2:0]       r_occ;

  logic [WIDTH-1:0] w_data_d [DEPTH];
  logic [DEPTH-1:0] w_valid_d;
  logic [2:0]       w_occ_d;

  // Priority below reset: flush, then stall (hold), then advance.
  always_comb begin
    w_data_d  = r_data;
    w_valid_d = r_valid;
    if (i_flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        w_data_d[i] = RESET_VAL;
      end
      w_valid_d = '0;
    end else if (!i_stall) begin
      w_data_d[0]  = i_d;
      w_valid_d[0] = i_d_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        w_data_d[i]  = r_data[i-1];
        w_valid_d[i] = r_valid[i-1];
      end
    end
  end

  // Popcount of the next valid vector so occupancy moves on the same edge as the stages.
  always_comb begin
    w_occ_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_occ_d = w_occ_d + 3'(w_valid_d[i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VAL;
      end
      r_valid <= '0;
      r_occ   <= '0;
    end else begin
      r_data  <= w_data_d;
      r_valid <= w_valid_d;
      r_occ   <= w_occ_d;
    end
  end

  assign o_q         = r_data[DEPTH-1];
  assign o_q_valid   = r_valid[DEPTH-1];
  assign o_occupancy = r_occ;

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating; flush does not clear it, only reset does.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_stall_cnt <= '0;
    end else if (!i_flush && i_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: four instances (DEPTH 1..4, mixed reset values) share one stimulus
// stream and are checked against an array-based pipeline model.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst_n;
  logic [63:0] d;
  logic        d_valid;
  logic        stall;
  logic        flush;

  logic [63:0] w_q   [4];
  logic        w_qv  [4];
  logic [2:0]  w_occ [4];
  logic [15:0] w_cnt [4];

  int n_cmp;
  int n_bad;

  // Reference model state, indexed [instance][stage].
  logic [63:0] m_data  [4][4];
  logic        m_valid [4][4];
  int          m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(64), .DEPTH(1), .RESET_VAL(64'h0)) u_d1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_d(d), .i_d_valid(d_valid), .i_stall(stall),
    .i_flush(flush), .o_q(w_q[0]), .o_q_valid(w_qv[0]), .o_occupancy(w_occ[0]),
    .o_stall_cnt(w_cnt[0]));
  pipe_stage_reg #(.WIDTH(64), .DEPTH(2), .RESET_VAL(64'hFFFF_FFFF_FFFF_FFFF)) u_d2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_d(d), .i_d_valid(d_valid), .i_stall(stall),
    .i_flush(flush), .o_q(w_q[1]), .o_q_valid(w_qv[1]), .o_occupancy(w_occ[1]),
    .o_stall_cnt(w_cnt[1]));
  pipe_stage_reg #(.WIDTH(64), .DEPTH(3), .RESET_VAL(64'h0)) u_d3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_d(d), .i_d_valid(d_valid), .i_stall(stall),
    .i_flush(flush), .o_q(w_q[2]), .o_q_valid(w_qv[2]), .o_occupancy(w_occ[2]),
    .o_stall_cnt(w_cnt[2]));
  pipe_stage_reg #(.WIDTH(64), .DEPTH(4), .RESET_VAL(64'h5A5A_0000_A5A5_1234)) u_d4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_d(d), .i_d_valid(d_valid), .i_stall(stall),
    .i_flush(flush), .o_q(w_q[3]), .o_q_valid(w_qv[3]), .o_occupancy(w_occ[3]),
    .o_stall_cnt(w_cnt[3]));

  function automatic int dep(input int k);
    return k + 1;
  endfunction

  function automatic logic [63:0] rv(input int k);
    case (k)
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'h5A5A_0000_A5A5_1234;
      default: return 64'h0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear(input bit clr_cnt);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        m_data[k][j]  = rv(k);
        m_valid[k][j] = 1'b0;
      end
    end
    if (clr_cnt) m_cnt = 0;
  endtask

  task automatic model_edge(input logic r, input logic [63:0] dd, input logic dv,
                            input logic st, input logic fl);
    if (!r) model_clear(1'b1);
    else if (fl) model_clear(1'b0);
    else if (st) begin
      if (m_cnt < 65535) m_cnt++;
    end else begin
      for (int k = 0; k < 4; k++) begin
        for (int j = dep(k) - 1; j > 0; j--) begin
          m_data[k][j]  = m_data[k][j-1];
          m_valid[k][j] = m_valid[k][j-1];
        end
        m_data[k][0]  = dd;
        m_valid[k][0] = dv;
      end
    end
  endtask

  task automatic compare_all();
    int occ;
    logic [15:0] exp_cnt;
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    exp_cnt = 16'(m_cnt);
`else
    exp_cnt = 16'h0000;
`endif
    for (int k = 0; k < 4; k++) begin
      occ = 0;
      for (int j = 0; j < dep(k); j++) occ += int'(m_valid[k][j]);
      check_eq($sformatf("q[D%0d]", dep(k)), w_q[k], m_data[k][dep(k)-1]);
      check_eq($sformatf("q_valid[D%0d]", dep(k)), 64'(w_qv[k]), 64'(m_valid[k][dep(k)-1]));
      check_eq($sformatf("occupancy[D%0d]", dep(k)), 64'(w_occ[k]), 64'(occ));
      check_eq($sformatf("stall_cnt[D%0d]", dep(k)), 64'(w_cnt[k]), 64'(exp_cnt));
    end
  endtask

  // Drive away from the edge, apply the edge, then sample 1 time unit later.
  task automatic step(input logic r, input logic [63:0] dd, input logic dv,
                      input logic st, input logic fl);
    rst_n = r; d = dd; d_valid = dv; stall = st; flush = fl;
    @(posedge clk);
    model_edge(r, dd, dv, st, fl);
    #1;
    compare_all();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; m_cnt = 0;
    model_clear(1'b1);
    rst_n = 1'b0; d = '0; d_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    #2;

    // Reset held for two edges with live input, then release.
    step(1'b0, 64'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    check_eq("reset_q_d1", w_q[0], 64'h0);
    check_eq("reset_occ_d1", 64'(w_occ[0]), 64'd0);
    step(1'b1, 64'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    check_eq("release_q_d1", w_q[0], 64'hDEAD_BEEF);
    check_eq("release_occ_d1", 64'(w_occ[0]), 64'd1);

    // Latency: 1,2,3,4 back to back.
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
      if (i == 3) check_eq("latency_q_d3", w_q[2], 64'd1);
      if (i == 4) check_eq("latency_q_next_d3", w_q[2], 64'd2);
    end
    check_eq("latency_occ_d3", 64'(w_occ[2]), 64'd3);

    // Stall holds: DEPTH=2 loaded with 0x20 (head) then 0x10.
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h20, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'h10, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 64'h99, 1'b1, 1'b1, 1'b0);
    check_eq("stall_hold_q_d2", w_q[1], 64'h20);
    check_eq("stall_hold_occ_d2", 64'(w_occ[1]), 64'd2);
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    check_eq("stall_cnt_3", 64'(w_cnt[1]), 64'd3);
`endif
    step(1'b1, 64'h99, 1'b1, 1'b0, 1'b0);
    check_eq("stall_release_q_d2", w_q[1], 64'h10);
    step(1'b1, 64'h77, 1'b0, 1'b0, 1'b0);
    check_eq("stall_release2_q_d2", w_q[1], 64'h99);

    // Flush wins over stall on the same edge.
    step(1'b1, 64'hAB, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'hCD, 1'b1, 1'b1, 1'b1);
    check_eq("flush_q_d2", w_q[1], 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("flush_qv_d2", 64'(w_qv[1]), 64'd0);
    check_eq("flush_occ_d2", 64'(w_occ[1]), 64'd0);

    // Reset during stall with 3 valid entries in DEPTH=4.
    for (int i = 0; i < 3; i++) step(1'b1, 64'(i + 7), 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    check_eq("midreset_occ_d4", 64'(w_occ[3]), 64'd0);
    check_eq("midreset_cnt", 64'(w_cnt[3]), 64'd0);
    step(1'b1, 64'h5, 1'b1, 1'b0, 1'b0);
    check_eq("postreset_occ_d4", 64'(w_occ[3]), 64'd1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) != 0), {$urandom, $urandom}, 1'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    end

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    // Counter saturation.
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) step(1'b1, 64'(i), 1'b1, 1'b1, 1'b0);
    check_eq("stall_cnt_sat", 64'(w_cnt[0]), 64'hFFFF);
    step(1'b1, 64'h1, 1'b1, 1'b1, 1'b1);
    check_eq("stall_cnt_flush_keep", 64'(w_cnt[0]), 64'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
